// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer: error counter sizing and
// default datapath geometry.
package stream_demux_pkg;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 8;

endpackage

// File: rtl/stream_demux_if.sv
// Input stream plus per-channel output streams of the demultiplexer.
// The master drives the input and the channel readies; the slave is the demux.
interface stream_demux_if #(
  parameter int DATA_W = stream_demux_pkg::DEF_DATA_W,
  parameter int NUM_CH = stream_demux_pkg::DEF_NUM_CH
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/stream_demux_onehot_dec.sv
// Channel index to one-hot decode; indices at or beyond NUM_CH give all zeros,
// which the demux uses to detect an out-of-range select.
module onehot_dec #(
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bit
      assign onehot[gi] = (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/stream_demux.sv
// One-entry stream demultiplexer: a single held payload fans out to one channel
// or to all channels, and each channel retires its copy independently.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic [ERR_W-1:0] err_cnt
);

  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_next;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_next;
  logic [NUM_CH-1:0] sel_onehot;
  logic [ERR_W-1:0]  err_next;
  logic              accept;
  logic              sel_oor;

  onehot_dec #(.NUM_CH(NUM_CH)) u_dec (
    .sel    (bus.in_sel),
    .onehot (sel_onehot)
  );

  // Ready as soon as every still-pending lane is handshaking this cycle.
  assign bus.in_ready = ((pend_q & ~bus.out_ready) == '0);
  assign accept       = bus.in_valid & bus.in_ready;
  assign sel_oor      = ~bus.in_bcast & (sel_onehot == '0);

  always_comb begin
    hold_next = hold_q;
    pend_next = pend_q & ~bus.out_ready;
    err_next  = err_cnt;
    if (accept) begin
      // A new load overrides the drain so back-to-back transfers have no bubble.
      hold_next = bus.in_data;
      pend_next = bus.in_bcast ? '1 : sel_onehot;
      if (sel_oor && (err_cnt != ERR_SAT)) begin
        err_next = err_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      pend_q  <= '0;
      err_cnt <= '0;
    end else begin
      hold_q  <= hold_next;
      pend_q  <= pend_next;
      err_cnt <= err_next;
    end
  end

  assign bus.out_valid = pend_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign bus.out_data[gi*DATA_W +: DATA_W] = pend_q[gi] ? hold_q : '0;
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux.sv
// Randomised and directed bench for stream_demux, running an 8-channel and a
// 6-channel instance side by side against a per-lane behavioural model.
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(8), .NUM_CH(8)) if8 ();
  stream_demux_if #(.DATA_W(8), .NUM_CH(6)) if6 ();
  logic [7:0] err8;
  logic [7:0] err6;

  stream_demux #(.DATA_W(8), .NUM_CH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave), .err_cnt(err8)
  );
  stream_demux #(.DATA_W(8), .NUM_CH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(if6.slave), .err_cnt(err6)
  );

  int errors = 0;
  int checks = 0;
  int n_acc8 = 0;

  // Model state: index 0 is the 8-channel instance, index 1 the 6-channel one.
  int         m_n [2] = '{8, 6};
  bit         m_pend [2][8];
  logic [7:0] m_hold [2];
  int         m_err [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready(input int d, input logic [7:0] rdy);
    for (int k = 0; k < m_n[d]; k++)
      if (m_pend[d][k] && !rdy[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] m_valid(input int d);
    logic [63:0] r = '0;
    for (int k = 0; k < m_n[d]; k++) r[k] = m_pend[d][k];
    return r;
  endfunction

  function automatic logic [63:0] m_data(input int d);
    logic [63:0] r = '0;
    for (int k = 0; k < m_n[d]; k++)
      if (m_pend[d][k]) r[k*8 +: 8] = m_hold[d];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) m_pend[d][k] = 1'b0;
      m_hold[d] = '0;
      m_err[d]  = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [7:0] data, input int sel,
                            input bit bc, input bit v, input logic [7:0] rdy);
    if (v && m_ready(d, rdy)) begin
      m_hold[d] = data;
      for (int k = 0; k < m_n[d]; k++) m_pend[d][k] = bc || (k == sel);
      if (!bc && sel >= m_n[d]) m_err[d] = (m_err[d] < 255) ? m_err[d] + 1 : 255;
    end else begin
      for (int k = 0; k < m_n[d]; k++)
        if (rdy[k]) m_pend[d][k] = 1'b0;
    end
  endtask

  task automatic check_all(input logic [7:0] rdy);
    chk("in_ready8",  64'(if8.in_ready),  64'(m_ready(0, rdy)));
    chk("out_valid8", 64'(if8.out_valid), m_valid(0));
    chk("out_data8",  64'(if8.out_data),  m_data(0));
    chk("err_cnt8",   64'(err8),          64'(m_err[0]));
    chk("in_ready6",  64'(if6.in_ready),  64'(m_ready(1, rdy)));
    chk("out_valid6", 64'(if6.out_valid), m_valid(1));
    chk("out_data6",  64'(if6.out_data),  m_data(1));
    chk("err_cnt6",   64'(err6),          64'(m_err[1]));
  endtask

  // One clock: drive at the falling edge, check, let the rising edge act, return at the next falling edge.
  task automatic cycle(input logic [7:0] data, input int sel, input bit bc,
                       input bit v, input logic [7:0] rdy);
    bit a8;
    bit a6;
    if8.in_data = data;  if8.in_sel = 3'(sel); if8.in_bcast = bc; if8.in_valid = v;
    if8.out_ready = rdy;
    if6.in_data = data;  if6.in_sel = 3'(sel); if6.in_bcast = bc; if6.in_valid = v;
    if6.out_ready = rdy[5:0];
    #1;
    check_all(rdy);
    a8 = v && m_ready(0, rdy);
    a6 = v && m_ready(1, rdy);
    if (v && if8.in_ready) n_acc8++;
    if (a8 || a6)
      $display("txn t=%0t data=%h sel=%0d bcast=%0b acc8=%0b acc6=%0b", $time, data, sel, bc, a8, a6);
    @(posedge clk);
    model_step(0, data, sel, bc, v, rdy);
    model_step(1, data, sel, bc, v, rdy);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid8"}, 64'(if8.out_valid), 64'd0);
    chk({tag, "_data8"},  64'(if8.out_data),  64'd0);
    chk({tag, "_ready8"}, 64'(if8.in_ready),  64'd1);
    chk({tag, "_err8"},   64'(err8),          64'd0);
    chk({tag, "_valid6"}, 64'(if6.out_valid), 64'd0);
    chk({tag, "_err6"},   64'(err6),          64'd0);
  endtask

  initial begin
    if8.in_data = '0; if8.in_sel = '0; if8.in_bcast = 1'b0; if8.in_valid = 1'b0; if8.out_ready = '0;
    if6.in_data = '0; if6.in_sel = '0; if6.in_bcast = 1'b0; if6.in_valid = 1'b0; if6.out_ready = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_checks("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Unicast to lane 3.
    cycle(8'hA5, 3, 1'b0, 1'b1, 8'hFF);
    chk("uni_valid", 64'(if8.out_valid), 64'h08);
    chk("uni_lane3", 64'(if8.out_data),  64'h00000000A5000000);

    // Lane 5 stalls for four cycles while a second input waits.
    cycle(8'h3C, 5, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      cycle(8'h55, 2, 1'b0, 1'b1, 8'hDF);
      chk("stall_ready", 64'(if8.in_ready), 64'd0);
      chk("stall_lane5", 64'(if8.out_data[47:40]), 64'h3C);
    end
    cycle(8'h55, 2, 1'b0, 1'b1, 8'hFF);
    chk("stall_next", 64'(if8.out_valid), 64'h04);
    chk("stall_lane2", 64'(if8.out_data[23:16]), 64'h55);

    // Broadcast drained in two halves.
    cycle(8'h77, 0, 1'b1, 1'b1, 8'hFF);
    chk("bc_valid0", 64'(if8.out_valid), 64'hFF);
    chk("bc_data",   64'(if8.out_data),  64'h7777777777777777);
    cycle(8'h00, 0, 1'b0, 1'b0, 8'h0F);
    chk("bc_valid1", 64'(if8.out_valid), 64'hF0);
    chk("bc_ready1", 64'(if8.in_ready),  64'd0);
    cycle(8'h00, 0, 1'b0, 1'b0, 8'hF0);
    chk("bc_valid2", 64'(if8.out_valid), 64'h00);

    // Back-to-back walk over all lanes.
    n_acc8 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(8'(i * 17 + 1), i, 1'b0, 1'b1, 8'hFF);
      chk("b2b_valid", 64'(if8.out_valid), 64'(1) << i);
      chk("b2b_lane",  64'(if8.out_data[i*8 +: 8]), 64'(i * 17 + 1));
    end
    chk("b2b_accepts", 64'(n_acc8), 64'd8);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rdy;
      rdy = 8'($urandom);
      if ($urandom_range(0, 1) == 0) rdy = 8'hFF;
      cycle(8'($urandom), int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, rdy);
    end

    // Out-of-range select on the 6-channel instance until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      cycle(8'(i), 7, 1'b0, 1'b1, 8'hFF);
      chk("oor_valid6", 64'(if6.out_valid), 64'd0);
    end
    chk("oor_err6", 64'(err6), 64'd255);

    // Reset while lanes 4..7 of a broadcast are still pending.
    cycle(8'h99, 0, 1'b1, 1'b1, 8'hFF);
    cycle(8'h00, 0, 1'b0, 1'b0, 8'h0F);
    chk("mid_pend", 64'(if8.out_valid), 64'hF0);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h11, 1, 1'b0, 1'b1, 8'hFF);
    chk("post_valid", 64'(if8.out_valid), 64'h02);
    chk("post_lane1", 64'(if8.out_data[15:8]), 64'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
